// File: rtl/alu_pkg.sv
// Shared types for the ALU issue path: operation codes, RV32I opcodes and the
// buffered issue entry carried from decode into the EX stage.
package alu_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [3:0] {
        ALU_ADD     = 4'h0,
        ALU_SUB     = 4'h1,
        ALU_XOR     = 4'h2,
        ALU_OR      = 4'h3,
        ALU_AND     = 4'h4,
        ALU_SRL     = 4'h5,
        ALU_SLL     = 4'h6,
        ALU_SRA     = 4'h7,
        ALU_SLT     = 4'h8,
        ALU_SLTU    = 4'h9,
        ALU_EQ      = 4'hA,
        ALU_NE      = 4'hB,
        ALU_GE      = 4'hC,
        ALU_LT      = 4'hD,
        ALU_ILLEGAL = 4'hF
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        alu_op_e             op;
        logic [DATA_W-1:0]   srca;
        logic [DATA_W-1:0]   srcb;
        logic [DATA_W-1:0]   rs2;
        logic                br_inv;
        logic                illegal;
    } issue_entry_t;

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic alu_op_e arith_op(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational RV32I decode into an ALU operation code plus selected
// SrcA/SrcB; unsupported encodings become an illegal entry with zero operands.
module alu_op_decoder
    import alu_pkg::*;
(
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] rs1,
    input  logic [DATA_W-1:0] rs2,
    output issue_entry_t      entry
);

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [DATA_W-1:0] imm_i;
    logic [DATA_W-1:0] imm_s;
    logic [DATA_W-1:0] imm_u;
    logic [DATA_W-1:0] imm_j;
    logic [DATA_W-1:0] shamt;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{(DATA_W-12){instr[31]}}, instr[31:20]};
    assign imm_s  = {{(DATA_W-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u  = {instr[31:12], 12'h000};
    assign imm_j  = {{(DATA_W-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign shamt  = {{(DATA_W-5){1'b0}}, instr[24:20]};

    logic              legal;
    alu_op_e           op;
    logic [DATA_W-1:0] srca;
    logic [DATA_W-1:0] srcb;
    logic              br_inv;

    always_comb begin
        legal  = 1'b1;
        op     = ALU_ADD;
        srca   = rs1;
        srcb   = imm_i;
        br_inv = 1'b0;
        case (opcode)
            OPC_OP: begin
                op    = arith_op(funct3, instr[30]);
                srcb  = rs2;
                legal = (funct7 == 7'b0000000) ||
                        ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                // ADDI never becomes SUB, so instr[30] only matters for shifts
                op = arith_op(funct3, (funct3 == 3'b101) && instr[30]);
                if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
                    srcb  = shamt;
                    legal = (funct7 == 7'b0000000) ||
                            ((funct3 == 3'b101) && (funct7 == 7'b0100000));
                end
            end
            OPC_LOAD:  legal = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            OPC_STORE: begin
                srcb  = imm_s;
                legal = (funct3 inside {3'b000, 3'b001, 3'b010});
            end
            OPC_JALR:  legal = (funct3 == 3'b000);
            OPC_LUI: begin
                srca = '0;
                srcb = imm_u;
            end
            OPC_AUIPC: begin
                srca = pc;
                srcb = imm_u;
            end
            OPC_JAL: begin
                srca = pc;
                srcb = imm_j;
            end
            OPC_BRANCH: begin
                srcb = rs2;
                case (funct3)
                    3'b000: op = ALU_EQ;
                    3'b001: op = ALU_NE;
                    3'b100: op = ALU_LT;
                    3'b101: op = ALU_GE;
                    3'b110: op = ALU_SLTU;
                    3'b111: begin
                        op     = ALU_SLTU;
                        br_inv = 1'b1;
                    end
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        entry         = '0;
        entry.rs2     = rs2;
        entry.illegal = ~legal;
        if (legal) begin
            entry.op     = op;
            entry.srca   = srca;
            entry.srcb   = srcb;
            entry.br_inv = br_inv;
        end else begin
            entry.op = ALU_ILLEGAL;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue register feeding the ALU: decoded entries are held in a
// 2-entry skid buffer (main drives the outputs, skid absorbs one stall).
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [DATA_WIDTH-1:0]    in_pc,
    input  logic [DATA_WIDTH-1:0]    in_rs1,
    input  logic [DATA_WIDTH-1:0]    in_rs2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] out_op,
    output logic [DATA_WIDTH-1:0]    out_srca,
    output logic [DATA_WIDTH-1:0]    out_srcb,
    output logic [DATA_WIDTH-1:0]    out_rs2,
    output logic                     out_br_inv,
    output logic                     out_illegal
);

    issue_entry_t decoded;
    issue_entry_t main_q;
    issue_entry_t skid_q;
    logic         main_valid;
    logic         skid_valid;
    logic         accept;
    logic         main_free;

    alu_op_decoder u_decoder (
        .instr (in_instr),
        .pc    (in_pc),
        .rs1   (in_rs1),
        .rs2   (in_rs2),
        .entry (decoded)
    );

    assign in_ready  = ~skid_valid;
    assign accept    = in_valid & in_ready & ~flush;
    assign main_free = ~main_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            // accept is impossible while skid is occupied, so skid simply empties
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= accept;
                if (accept) begin
                    main_q <= decoded;
                end
            end
        end else if (accept) begin
            skid_q     <= decoded;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid   = main_valid;
    assign out_op      = main_q.op;
    assign out_srca    = main_q.srca;
    assign out_srcb    = main_q.srcb;
    assign out_rs2     = main_q.rs2;
    assign out_br_inv  = main_q.br_inv;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: expected entries are queued when an
// input is accepted and popped whenever the DUT completes an output transfer.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_op;
    logic [31:0] out_srca;
    logic [31:0] out_srcb;
    logic [31:0] out_rs2;
    logic        out_br_inv;
    logic        out_illegal;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r2;
        logic        inv;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_srca    (out_srca),
        .out_srcb    (out_srcb),
        .out_rs2     (out_rs2),
        .out_br_inv  (out_br_inv),
        .out_illegal (out_illegal)
    );

    function automatic exp_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] r2, input logic inv, input logic ill);
        exp_t e;
        e = {op, a, b, r2, inv, ill};
        return e;
    endfunction

    // Output transfers complete at the next rising edge; sampled on the falling edge.
    always @(negedge clk) begin
        exp_t got;
        exp_t want;
        if (rst_n && out_valid && out_ready && !flush) begin
            got = {out_op, out_srca, out_srcb, out_rs2, out_br_inv, out_illegal};
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got=%h (no entry expected)", got);
            end else begin
                want = sb.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("FAIL sb_entry got=%h exp=%h", got, want);
                end
            end
        end
    end

    // Called at posedge+1; holds in_valid until accepted (bounded).
    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] r1,
                         input logic [31:0] r2, input exp_t e, input bit track);
        int n;
        in_instr = instr;
        in_pc    = pc;
        in_rs1   = r1;
        in_rs2   = r2;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL drive_timeout in_ready=%b exp=1", in_ready);
            in_valid = 1'b0;
            return;
        end
        if (track) sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0;
        #3;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++; $display("FAIL reset_hs got=%b exp=01", {out_valid, in_ready});
        end
        checks++;
        if ({out_op, out_srca, out_srcb, out_rs2, out_br_inv, out_illegal} !== '0) begin
            failures++; $display("FAIL reset_data op=%h a=%h b=%h exp=0", out_op, out_srca, out_srcb);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++; $display("FAIL reset_first_cycle got=%b exp=01", {out_valid, in_ready});
        end
    endtask

    task automatic test_latency;
        out_ready = 1'b1;
        in_instr = 32'h002081B3; in_pc = 32'h0; in_rs1 = 32'd5; in_rs2 = 32'd7; in_valid = 1'b1;
        sb.push_back(mk(4'h0, 32'd5, 32'd7, 32'd7, 1'b0, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_op, out_srca, out_srcb} !== {1'b1, 4'h0, 32'd5, 32'd7}) begin
            failures++;
            $display("FAIL add_latency valid=%b op=%h a=%h b=%h exp=1/0/5/7", out_valid, out_op, out_srca, out_srcb);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_decode;
        out_ready = 1'b1;
        drive(32'h402081B3, 32'h0, 32'd20, 32'd7, mk(4'h1, 32'd20, 32'd7, 32'd7, 1'b0, 1'b0), 1'b1);
        drive(32'h4040D293, 32'h0, 32'h8000_0000, 32'h55, mk(4'h7, 32'h8000_0000, 32'd4, 32'h55, 1'b0, 1'b0), 1'b1);
        checks++;
        if ({out_op, out_srcb} !== {4'h7, 32'd4}) begin
            failures++; $display("FAIL srai op=%h srcb=%h exp=7/4", out_op, out_srcb);
        end
        drive(32'hFFF00093, 32'h0, 32'd10, 32'd0, mk(4'h0, 32'd10, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0), 1'b1);
        checks++;
        if (out_srcb !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL addi_neg srcb=%h exp=ffffffff", out_srcb);
        end
        drive(32'h0020F063, 32'h0, 32'd3, 32'd9, mk(4'h9, 32'd3, 32'd9, 32'd9, 1'b1, 1'b0), 1'b1);
        checks++;
        if ({out_op, out_br_inv} !== {4'h9, 1'b1}) begin
            failures++; $display("FAIL bgeu op=%h inv=%b exp=9/1", out_op, out_br_inv);
        end
        drive(32'h0020C063, 32'h0, 32'd3, 32'd9, mk(4'hD, 32'd3, 32'd9, 32'd9, 1'b0, 1'b0), 1'b1);
        drive(32'h123452B7, 32'h0, 32'h77, 32'h66, mk(4'h0, 32'h0, 32'h1234_5000, 32'h66, 1'b0, 1'b0), 1'b1);
        drive(32'h0020A423, 32'h0, 32'h100, 32'hCAFE, mk(4'h0, 32'h100, 32'd8, 32'hCAFE, 1'b0, 1'b0), 1'b1);
        drive(32'h00001097, 32'h400, 32'h9, 32'h3, mk(4'h0, 32'h400, 32'h1000, 32'h3, 1'b0, 1'b0), 1'b1);
        drive(32'hFFE0B093, 32'h0, 32'd1, 32'd0, mk(4'h9, 32'd1, 32'hFFFF_FFFE, 32'd0, 1'b0, 1'b0), 1'b1);
        drive(32'h0000007F, 32'h0, 32'd1, 32'd2, mk(4'hF, 32'd0, 32'd0, 32'd2, 1'b0, 1'b1), 1'b1);
        checks++;
        if ({out_valid, out_illegal, out_op} !== {1'b1, 1'b1, 4'hF}) begin
            failures++; $display("FAIL illegal valid=%b ill=%b op=%h exp=1/1/f", out_valid, out_illegal, out_op);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (in_ready !== 1'b1) begin
                failures++; $display("FAIL b2b_ready idx=%0d got=%b exp=1", i, in_ready);
            end
            drive(32'h002081B3, 32'h0, i, 100 + i, mk(4'h0, i, 100 + i, 100 + i, 1'b0, 1'b0), 1'b1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall;
        out_ready = 1'b0;
        drive(32'h002081B3, 32'h0, 32'd11, 32'd12, mk(4'h0, 32'd11, 32'd12, 32'd12, 1'b0, 1'b0), 1'b1);
        checks++;
        if ({out_valid, in_ready} !== 2'b11) begin
            failures++; $display("FAIL stall_first got=%b exp=11", {out_valid, in_ready});
        end
        drive(32'h402081B3, 32'h0, 32'd21, 32'd22, mk(4'h1, 32'd21, 32'd22, 32'd22, 1'b0, 1'b0), 1'b1);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL stall_full in_ready=%b exp=0", in_ready);
        end
        in_instr = 32'h0020C063; in_rs1 = 32'd31; in_rs2 = 32'd32; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({in_ready, out_valid, out_srca} !== {1'b0, 1'b1, 32'd11}) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d rdy=%b valid=%b a=%h exp=0/1/b", c, in_ready, out_valid, out_srca);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, out_srca} !== {1'b1, 32'd21}) begin
            failures++; $display("FAIL skid_move rdy=%b a=%h exp=1/15", in_ready, out_srca);
        end
        sb.push_back(mk(4'hD, 32'd31, 32'd32, 32'd32, 1'b0, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        drive(32'h002081B3, 32'h0, 32'hA1, 32'hA2, '0, 1'b0);
        drive(32'h002081B3, 32'h0, 32'hB1, 32'hB2, '0, 1'b0);
        in_instr = 32'h002081B3; in_rs1 = 32'hD1; in_rs2 = 32'hD2; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++; $display("FAIL flush_full got=%b exp=01", {out_valid, in_ready});
        end
        // flush while only main is occupied, so the presented input is acceptable
        drive(32'h002081B3, 32'h0, 32'hC1, 32'hC2, '0, 1'b0);
        in_instr = 32'h002081B3; in_rs1 = 32'hE1; in_rs2 = 32'hE2; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++; $display("FAIL flush_drop got=%b exp=01", {out_valid, in_ready});
        end
        out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        drive(32'h002081B3, 32'h0, 32'hF1, 32'hF2, mk(4'h0, 32'hF1, 32'hF2, 32'hF2, 1'b0, 1'b0), 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        drive(32'h002081B3, 32'h0, 32'h51, 32'h52, '0, 1'b0);
        drive(32'h002081B3, 32'h0, 32'h61, 32'h62, '0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, out_srca} !== {1'b0, 1'b1, 32'd0}) begin
            failures++; $display("FAIL reset_mid valid=%b rdy=%b a=%h exp=0/1/0", out_valid, in_ready, out_srca);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_mid_after valid=%b exp=0", out_valid);
        end
    endtask

    task automatic test_drain_done;
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL sb_leftover got=%0d exp=0", sb.size());
        end
    endtask

    initial begin
        test_reset;
        test_latency;
        test_decode;
        test_back_to_back;
        test_stall;
        test_flush;
        test_drain_done;
        test_reset_mid;
        test_drain_done;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
